// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - board RAM read/write arbiter; optional ARB_STATS_EN conflict counter
module board_ram_arbiter #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           rd_req,
    input  logic [2:0]           rd_lock,
    input  logic [ADDR_BITS-1:0] rd_addr0,
    input  logic [ADDR_BITS-1:0] rd_addr1,
    input  logic [ADDR_BITS-1:0] rd_addr2,
    output logic [2:0]           rd_gnt,
    output logic [2:0]           rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    input  logic [DATA_BITS-1:0] ram_rd_data,
    input  logic [1:0]           wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr0,
    input  logic [ADDR_BITS-1:0] wr_addr1,
    input  logic [DATA_BITS-1:0] wr_data0,
    input  logic [DATA_BITS-1:0] wr_data1,
    output logic [1:0]           wr_ack,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [DATA_BITS-1:0] ram_wr_data,
    output logic [7:0]           conflict_count
);

    logic [1:0]           rr_ptr;
    logic [2:0]           gnt_next;
    logic [1:0]           gnt_next_idx;
    logic                 fwd_hit;
    logic [DATA_BITS-1:0] fwd_data;

    // Next owner: a locked, still-requesting owner keeps the grant; otherwise
    // search the requesters starting just after the last owner.
    always_comb begin
        gnt_next = 3'b000;
        if ((rd_gnt & rd_req & rd_lock) != 3'b000) begin
            gnt_next = rd_gnt;
        end else begin
            case (rr_ptr)
                2'd0: begin
                    if (rd_req[1])      gnt_next = 3'b010;
                    else if (rd_req[2]) gnt_next = 3'b100;
                    else if (rd_req[0]) gnt_next = 3'b001;
                end
                2'd1: begin
                    if (rd_req[2])      gnt_next = 3'b100;
                    else if (rd_req[0]) gnt_next = 3'b001;
                    else if (rd_req[1]) gnt_next = 3'b010;
                end
                default: begin
                    if (rd_req[0])      gnt_next = 3'b001;
                    else if (rd_req[1]) gnt_next = 3'b010;
                    else if (rd_req[2]) gnt_next = 3'b100;
                end
            endcase
        end
    end

    // Index of the new owner, used to move the round-robin pointer.
    always_comb begin
        gnt_next_idx = 2'd0;
        case (gnt_next)
            3'b010:  gnt_next_idx = 2'd1;
            3'b100:  gnt_next_idx = 2'd2;
            default: gnt_next_idx = 2'd0;
        endcase
    end

    // Owner register and pointer; pointer starts at 2 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_gnt <= 3'b000;
            rr_ptr <= 2'd2;
        end else begin
            rd_gnt <= gnt_next;
            if (gnt_next != 3'b000) begin
                rr_ptr <= gnt_next_idx;
            end
        end
    end

    // RAM read address follows the current owner, 0 when idle.
    always_comb begin
        ram_rd_addr = '0;
        case (rd_gnt)
            3'b001:  ram_rd_addr = rd_addr0;
            3'b010:  ram_rd_addr = rd_addr1;
            3'b100:  ram_rd_addr = rd_addr2;
            default: ram_rd_addr = '0;
        endcase
    end

    // Fixed-priority write mux: mem reset (bit0) beats move commit (bit1).
    always_comb begin
        wr_ack      = 2'b00;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (wr_req[0]) begin
            wr_ack      = 2'b01;
            ram_wr_addr = wr_addr0;
            ram_wr_data = wr_data0;
        end else if (wr_req[1]) begin
            wr_ack      = 2'b10;
            ram_wr_addr = wr_addr1;
            ram_wr_data = wr_data1;
        end
    end

    assign ram_we = |wr_req;

    // Read pipeline: valid trails the grant by one cycle; a same-cycle write to
    // the issued address is captured so the stale RAM word can be overridden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 3'b000;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            rd_valid <= rd_gnt;
            fwd_hit  <= ram_we && (rd_gnt != 3'b000) && (ram_wr_addr == ram_rd_addr);
            fwd_data <= ram_wr_data;
        end
    end

    // Returned data: forwarded write data wins over the RAM output.
    always_comb begin
        rd_data = '0;
        if (rd_valid != 3'b000) begin
            rd_data = fwd_hit ? fwd_data : ram_rd_data;
        end
    end

`ifdef ARB_STATS_EN
    logic [7:0] conflict_q;
    logic       conflict_evt;

    assign conflict_evt = (wr_req == 2'b11) || ((rd_req & ~rd_gnt) != 3'b000);

    // Saturating count of cycles with a blocked read or write requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 8'd0;
        end else if (conflict_evt && (conflict_q != 8'hFF)) begin
            conflict_q <= conflict_q + 8'd1;
        end
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = 8'd0;
`endif

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - scoreboard testbench for board_ram_arbiter
module tb_board_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rd_req = '0;
    logic [2:0] rd_lock = '0;
    logic [5:0] rd_addr0 = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [2:0] rd_gnt, rd_valid;
    logic [1:0] rd_data;
    logic [5:0] ram_rd_addr;
    logic [1:0] ram_rd_data = '0;
    logic [1:0] wr_req = '0;
    logic [5:0] wr_addr0 = '0, wr_addr1 = '0;
    logic [1:0] wr_data0 = '0, wr_data1 = '0;
    logic [1:0] wr_ack;
    logic       ram_we;
    logic [5:0] ram_wr_addr;
    logic [1:0] ram_wr_data;
    logic [7:0] conflict_count;

    board_ram_arbiter #(.ADDR_BITS(6), .DATA_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_lock(rd_lock),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read (old data on same-address write), 1-cycle latency.
    logic [1:0] mem [64] = '{default: 2'b00};
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    typedef struct {
        int         due;
        int         req;
        logic [1:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int         m_owner = -1;
    int         m_last = 2;
    int         m_cnt = 0;
    logic [1:0] ref_mem [64] = '{default: 2'b00};

    function automatic logic [2:0] oh(int i);
        if (i < 0) return 3'b000;
        return 3'(1 << i);
    endfunction

    // Monitor: every rd_valid must match the oldest outstanding read, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("rd_valid_late", 32'(rd_valid), 32'(oh(e.req)));
            end
            if (rd_valid != 3'b000) begin
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("rd_valid", 32'(rd_valid), 32'(oh(e.req)));
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                end else begin
                    chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rd_valid_missing", 32'(rd_valid), 32'(oh(e.req)));
            end
        end
    end

    task automatic step(input logic [2:0] rq, input logic [2:0] lk,
                        input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                        input logic [1:0] wq, input logic [5:0] wa0, input logic [5:0] wa1,
                        input logic [1:0] wd0, input logic [1:0] wd1);
        logic [5:0] a [3];
        logic       we;
        logic [5:0] waddr;
        logic [1:0] wdata;
        logic [1:0] ack;
        int         nxt;
        exp_t       e;
        @(negedge clk);
        rd_req = rq; rd_lock = lk;
        rd_addr0 = a0; rd_addr1 = a1; rd_addr2 = a2;
        wr_req = wq; wr_addr0 = wa0; wr_addr1 = wa1; wr_data0 = wd0; wr_data1 = wd1;
        #1;
        a[0] = a0; a[1] = a1; a[2] = a2;
        we = 1'b0; waddr = '0; wdata = '0; ack = 2'b00;
        if (wq[0]) begin we = 1'b1; waddr = wa0; wdata = wd0; ack = 2'b01; end
        else if (wq[1]) begin we = 1'b1; waddr = wa1; wdata = wd1; ack = 2'b10; end

        chk("rd_gnt", 32'(rd_gnt), 32'(oh(m_owner)));
        chk("ram_rd_addr", 32'(ram_rd_addr), (m_owner >= 0) ? 32'(a[m_owner]) : 32'd0);
        chk("wr_ack", 32'(wr_ack), 32'(ack));
        chk("ram_we", 32'(ram_we), 32'(we));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(waddr));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(wdata));
        chk("conflict_count", 32'(conflict_count), 32'(m_cnt));

        if (m_owner >= 0) begin
            e.due  = cyc + 1;
            e.req  = m_owner;
            e.data = (we && waddr == a[m_owner]) ? wdata : ref_mem[a[m_owner]];
            sb.push_back(e);
        end
        if (we) ref_mem[waddr] = wdata;

`ifdef ARB_STATS_EN
        if (wq == 2'b11 || (rq & ~oh(m_owner)) != 3'b000)
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
`endif

        if (m_owner >= 0 && rq[m_owner] && lk[m_owner]) begin
            nxt = m_owner;
        end else begin
            nxt = -1;
            for (int k = 1; k <= 3; k++) begin
                if (nxt < 0 && rq[(m_last + k) % 3]) nxt = (m_last + k) % 3;
            end
        end
        if (nxt >= 0) m_last = nxt;
        m_owner = nxt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        rd_req = '0; rd_lock = '0; wr_req = '0;
        #1;
        chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_conflict_count", 32'(conflict_count), 32'd0);
        sb.delete();
        m_owner = -1;
        m_last  = 2;
        m_cnt   = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single requester: preload cell 9, then read it back
        step(3'b000, 3'b000, 0, 0, 0, 2'b01, 6'd9, 0, 2'b01, 0);
        for (int i = 0; i < 4; i++) step(3'b001, 3'b000, 6'd9, 0, 0, 2'b00, 0, 0, 0, 0);
        idle(2);

        // Round robin from reset with all three requesting
        do_reset();
        for (int i = 0; i < 9; i++) step(3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 2'b00, 0, 0, 0, 0);
        idle(2);

        // Lock: scanner owns and holds for 64 cycles, then releases
        step(3'b010, 3'b010, 0, 6'd4, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(3'b011, 3'b010, 6'd5, 6'd4, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(3'b011, 3'b000, 6'd5, 6'd4, 0, 2'b00, 0, 0, 0, 0);
        idle(2);

        // Forwarding: move commit to cell 20 while it is being read
        step(3'b001, 3'b000, 6'd20, 0, 0, 2'b00, 0, 0, 0, 0);
        step(3'b001, 3'b000, 6'd20, 0, 0, 2'b10, 0, 6'd20, 0, 2'b10);
        step(3'b001, 3'b000, 6'd20, 0, 0, 2'b00, 0, 0, 0, 0);
        idle(2);

        // Write priority, long enough to saturate the conflict counter
        for (int i = 0; i < 300; i++) step(3'b000, 3'b000, 0, 0, 0, 2'b11, 6'd5, 6'd6, 2'b01, 2'b10);
        idle(2);

        // Reset in the cycle after a grant, then re-grant
        step(3'b001, 3'b000, 6'd7, 0, 0, 2'b00, 0, 0, 0, 0);
        step(3'b001, 3'b000, 6'd7, 0, 0, 2'b00, 0, 0, 0, 0);
        step(3'b001, 3'b000, 6'd7, 0, 0, 2'b00, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 2'b00, 0, 0, 0, 0);

        // Randomized traffic on a small address window to provoke forwarding
        for (int i = 0; i < 1500; i++) begin
            step(3'($urandom), 3'($urandom & $urandom),
                 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                 2'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
        end
        idle(4);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
